// File: rtl/mac_result_writer_pkg.sv
// Shared types for the MAC result writer: result bundle entry and writer FSM states.
package mac_result_writer_pkg;

  localparam int MU_W = 18;
  localparam int ROWS = 4;

  typedef logic [ROWS-1:0][MU_W-1:0] mu_vec_t;

  // One captured ALU bundle; mu[0] is row 0 (MU1).
  typedef struct packed {
    mu_vec_t mu;
    logic    last;
  } res_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/mac_result_writer_fifo.sv
// res_fifo2: two-entry bundle buffer between the ALU strobe and the SRAM serialiser.
module res_fifo2
  import mac_result_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  res_entry_t push_data,
  input  logic       pop,
  output res_entry_t head,
  output logic       full,
  output logic       empty
);

  res_entry_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mac_result_writer.sv
// Serialises buffered 4-row MAC result bundles into the result SRAM, one word per cycle.
// Optional build macro RES_SAT_EN clamps each written result to SAT_MAX.
module mac_result_writer
  import mac_result_writer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int SAT_MAX = 32767
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              res_valid,
  input  logic              res_last,
  input  logic [MU_W-1:0]   mu1,
  input  logic [MU_W-1:0]   mu2,
  input  logic [MU_W-1:0]   mu3,
  input  logic [MU_W-1:0]   mu4,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              wr_done,
  output logic              overflow
);

  localparam int COL_W = ADDR_W - 2;

`ifdef RES_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  wr_state_t         state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              done_pend_q, done_d;
  logic              do_write;
  logic              push, pop, full, empty;
  res_entry_t        push_data, head;
  logic [DATA_W-1:0] wdata_d;

  function automatic logic [DATA_W-1:0] fmt_word(input logic [MU_W-1:0] v);
    if (SAT_ON && (DATA_W'(v) > DATA_W'(SAT_MAX)))
      return DATA_W'(SAT_MAX);
    return DATA_W'(v);
  endfunction

  assign push_data.mu   = {mu4, mu3, mu2, mu1};
  assign push_data.last = res_last;
  // A full FIFO rejects even if it pops this cycle; clr beats a coincident strobe.
  assign push = res_valid & ~full & ~clr;

  res_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // IDLE emits row 0 directly so the first write follows the push by one edge.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    pop      = 1'b0;
    do_write = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          do_write = 1'b1;
          row_d    = 2'd1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        do_write = 1'b1;
        row_d    = row_q + 2'd1;
        if (row_q == 2'd3) begin
          pop     = 1'b1;
          done_d  = head.last;
          col_d   = head.last ? '0 : col_q + 1'b1;
          state_d = full ? ST_WRITE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wdata_d = fmt_word(head.mu[row_q]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      col_q       <= '0;
      done_pend_q <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      wr_done     <= 1'b0;
      overflow    <= 1'b0;
    end else if (clr) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      col_q       <= '0;
      done_pend_q <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      wr_done     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_pend_q <= done_d;
      wr_done     <= done_pend_q;
      ram_we      <= do_write;
      if (do_write) begin
        ram_addr  <= {col_q, row_q};
        ram_wdata <= wdata_d;
      end
      if (res_valid && full) overflow <= 1'b1;
    end
  end

  // The registered write word still counts as work in flight.
  assign busy = ~empty | (state_q == ST_WRITE) | ram_we;

endmodule

// File: tb/tb_mac_result_writer.sv
// Scoreboard bench for mac_result_writer: directed bundles queue expected SRAM writes.
module tb_mac_result_writer;

  logic        clk = 1'b0;
  logic        rst, clr, res_valid, res_last;
  logic [17:0] mu1, mu2, mu3, mu4;
  logic        ram_we, busy, wr_done, overflow;
  logic [3:0]  ram_addr;
  logic [31:0] ram_wdata;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    total = 0;
  int    bad   = 0;
  int    done_cnt = 0;
  int    col   = 0;
  bit    prev_last = 0;
  bit    cur_last;

  always #5 clk = ~clk;

  mac_result_writer dut (
    .clk(clk), .rst(rst), .clr(clr), .res_valid(res_valid), .res_last(res_last),
    .mu1(mu1), .mu2(mu2), .mu3(mu3), .mu4(mu4),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .wr_done(wr_done), .overflow(overflow)
  );

  function automatic logic [31:0] exp_data(input logic [17:0] v);
`ifdef RES_SAT_EN
    if (v > 18'd32767) return 32'd32767;
`endif
    return {14'd0, v};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input logic [17:0] a, b, c, d, input bit last, input bit accept);
    logic [17:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    res_valid = 1'b1; res_last = last;
    mu1 = a; mu2 = b; mu3 = c; mu4 = d;
    if (accept) begin
      for (int r = 0; r < 4; r++)
        sb.push_back('{addr: 4'(col * 4 + r), data: exp_data(v[r]), last: (last && r == 3)});
      col = last ? 0 : (col + 1) % 4;
    end
    @(posedge clk); #1;
    res_valid = 1'b0; res_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy && !ram_we && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    col = 0;
  endtask

  // Monitor: every SRAM write pops one expectation; wr_done must follow a last-flagged word.
  always @(negedge clk) begin
    cur_last = 1'b0;
    if (!rst) begin
      prev_last = 1'b0;
    end else begin
      if (ram_we) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got addr=%0d data=%0d want no write", ram_addr, ram_wdata);
        end else begin
          mon_e = sb.pop_front();
          cur_last = mon_e.last;
          if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) begin
            bad++;
            $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                     ram_addr, ram_wdata, mon_e.addr, mon_e.data);
          end
        end
      end
      if (wr_done || prev_last) begin
        total++;
        if (wr_done !== prev_last) begin
          bad++;
          $display("FAIL wr_done got=%0d want=%0d", wr_done, prev_last);
        end
      end
      if (wr_done) done_cnt++;
      prev_last = cur_last;
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; res_valid = 1'b0; res_last = 1'b0;
    mu1 = '0; mu2 = '0; mu3 = '0; mu4 = '0;
    idle(2);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(wr_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    idle(1);

    // Single bundle: addr 0..3, data 1..4.
    send(18'd1, 18'd2, 18'd3, 18'd4, 1'b0, 1'b1);
    wait_idle("single");

    // Full matrix of four bundles from column 0, then one more wraps back to addr 0.
    pulse_clr();
    done_cnt = 0;
    send(18'd10, 18'd11, 18'd12, 18'd13, 1'b0, 1'b1); idle(7);
    send(18'd20, 18'd21, 18'd22, 18'd23, 1'b0, 1'b1); idle(7);
    send(18'd30, 18'd31, 18'd32, 18'd33, 1'b0, 1'b1); idle(7);
    send(18'd40, 18'd41, 18'd42, 18'd43, 1'b1, 1'b1); idle(7);
    wait_idle("matrix");
    check("matrix_done_cnt", 32'(done_cnt), 32'd1);
    send(18'd50, 18'd51, 18'd52, 18'd53, 1'b0, 1'b1);
    wait_idle("wrap");

    // Three strobes back to back: two written, third dropped, overflow sticky.
    send(18'd100, 18'd101, 18'd102, 18'd103, 1'b0, 1'b1);
    send(18'd200, 18'd201, 18'd202, 18'd203, 1'b0, 1'b1);
    send(18'd300, 18'd301, 18'd302, 18'd303, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf");
    idle(5);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Large value: clamped only in the saturating build.
    send(18'd40000, 18'd100, 18'd262143, 18'd32767, 1'b0, 1'b1);
    wait_idle("sat");

    // clr together with a strobe: bundle gone, column counter back to 0.
    check("pre_clr_col", 32'(col), 32'd1);
    clr = 1'b1; res_valid = 1'b1; mu1 = 18'd7; mu2 = 18'd7; mu3 = 18'd7; mu4 = 18'd7;
    @(posedge clk); #1;
    clr = 1'b0; res_valid = 1'b0;
    sb.delete(); col = 0;
    check("clr_busy", 32'(busy), 32'd0);
    idle(4);
    check("clr_no_write", 32'(busy), 32'd0);
    send(18'd5, 18'd6, 18'd7, 18'd8, 1'b0, 1'b1);
    wait_idle("after_clr");

    // Reset while row 2 is on the SRAM port.
    send(18'd60, 18'd61, 18'd62, 18'd63, 1'b0, 1'b1);
    idle(3);
    check("mid_row", 32'(ram_addr), 32'd6);
    rst = 1'b0;
    #1;
    sb.delete(); col = 0;
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    check("abort_wdata", ram_wdata, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("abort_hold_we", 32'(ram_we), 32'd0);
    end
    rst = 1'b1;
    idle(3);
    check("post_rst_we", 32'(ram_we), 32'd0);
    send(18'd9, 18'd8, 18'd7, 18'd6, 1'b0, 1'b1);
    wait_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
